// File: rtl/seq_multiplier_n.sv
// Sequential shift-and-add multiplier with optional two's complement operands.
// Operands are converted to magnitudes at load; the sign is reapplied at completion.
module seq_multiplier_n #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sign_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   result_q, result_d;

    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     acc_sh;
    logic [WIDTH-1:0]     q_sh;
    logic [CW-1:0]        rem;
    logic [WIDTH-1:0]     mask;
    logic [2*WIDTH-1:0]   prod;
    logic                 last;

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        acc_d    = acc_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;

        sum    = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
        acc_sh = sum[WIDTH:1];
        q_sh   = {sum[0], q_q[WIDTH-1:1]};
        // rem = shifts still owed after this one; mask selects the unprocessed Q bits
        rem    = cnt_q - CW'(1);
        mask   = ~({WIDTH{1'b1}} << rem);
        prod   = {acc_sh, q_sh} >> rem;
        last   = (cnt_q == CW'(1)) || (EARLY_EXIT && ((q_sh & mask) == '0));

        case (state_q)
            StIdle: begin
                if (start) begin
                    m_d    = (sign_mode && a[WIDTH-1]) ? -a : a;
                    q_d    = (sign_mode && b[WIDTH-1]) ? -b : b;
                    acc_d  = '0;
                    cnt_d  = CW'(WIDTH);
                    sign_d = sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = acc_sh;
                q_d   = q_sh;
                cnt_d = cnt_q - CW'(1);
                if (last) begin
                    result_d = sign_q ? -prod : prod;
                    state_d  = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            m_q      <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

endmodule
